// File: rtl/loom_scan_pkg.sv
// Shared command and FSM state encodings for the multi-chain scan controller.
// Optional build macro LOOM_SCAN_PARITY_EN is consumed by loom_scan_lane.
package loom_scan_pkg;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_CAPTURE = 3'd1,
    CMD_RESTORE = 3'd2,
    CMD_SWAP    = 3'd3
  } scan_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_SHIFT,
    ST_POST,
    ST_DONE
  } scan_state_e;

  // Codes 4..7 have no meaning and are rejected with an error completion.
  function automatic logic cmd_code_legal(input logic [2:0] code);
    return code <= 3'd3;
  endfunction

endpackage

// File: rtl/loom_scan_lane.sv
// One scan lane: shift buffer, fill mux, scan_in mux and optional parity.
// Parity flops exist only when LOOM_SCAN_PARITY_EN is defined.
module loom_scan_lane
  import loom_scan_pkg::*;
#(
  parameter int DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] load_data_i,
  input  logic                 shift_i,
  input  scan_cmd_e            mode_i,
  input  logic                 scan_out_i,
  output logic                 scan_in_o,
  output logic [DataWidth-1:0] lane_o,
  output logic                 parity_o
);

  logic [DataWidth-1:0] lane_reg;
  logic                 fill;

  assign fill   = (mode_i == CMD_RESTORE) ? 1'b0 : scan_out_i;
  assign lane_o = lane_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_reg <= '0;
    end else if (load_i) begin
      lane_reg <= load_data_i;
    end else if (shift_i) begin
      lane_reg <= {lane_reg[DataWidth-2:0], fill};
    end
  end

  // Capture recirculates the chain so its contents survive the read.
  always_comb begin
    scan_in_o = 1'b0;
    if (shift_i) begin
      scan_in_o = (mode_i == CMD_CAPTURE) ? scan_out_i : lane_reg[DataWidth-1];
    end
  end

`ifdef LOOM_SCAN_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_reg <= 1'b0;
    end else if (load_i) begin
      parity_reg <= 1'b0;
    end else if (shift_i) begin
      parity_reg <= parity_reg ^ scan_out_i;
    end
  end

  assign parity_o = parity_reg;
`else
  assign parity_o = 1'b0;
`endif

endmodule

// File: rtl/loom_scan_mchain_ctrl.sv
// Multi-chain scan controller: halts the DUT clock, shifts N bits per chain, resumes.
// Define LOOM_SCAN_PARITY_EN to get per-chain parity of shifted-out bits.
module loom_scan_mchain_ctrl
  import loom_scan_pkg::*;
#(
  parameter int NumChains  = 4,
  parameter int DataWidth  = 64,
  parameter int CountWidth = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [2:0]                     cmd_i,
  input  logic [CountWidth-1:0]          shift_count_i,
  input  logic [NumChains*DataWidth-1:0] shift_data_i,
  output logic [NumChains*DataWidth-1:0] shift_data_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic                           scan_enable_o,
  output logic [NumChains-1:0]           scan_in_o,
  input  logic [NumChains-1:0]           scan_out_i,
  output logic                           clk_gate_en_o,
  output logic [NumChains-1:0]           parity_o
);

  scan_state_e           state_reg;
  scan_cmd_e             cmd_reg;
  logic [CountWidth-1:0] cnt_reg;
  logic                  ready_reg, busy_reg, done_reg, err_reg, sen_reg, gate_reg;

  logic accept, cmd_is_nop, cmd_ok, lane_load, lane_shift;

  assign accept     = cmd_valid_i & ready_reg;
  assign cmd_is_nop = (cmd_i == 3'd0);
  assign cmd_ok     = cmd_code_legal(cmd_i) && (shift_count_i != '0) &&
                      (32'(shift_count_i) <= 32'(DataWidth));
  assign lane_load  = accept & ~cmd_is_nop & cmd_ok;
  assign lane_shift = (state_reg == ST_SHIFT);

  assign cmd_ready_o   = ready_reg;
  assign busy_o        = busy_reg;
  assign done_o        = done_reg;
  assign err_o         = err_reg;
  assign scan_enable_o = sen_reg;
  assign clk_gate_en_o = gate_reg;

  // Outputs are registered alongside the state so the gate enable is glitch-free.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      cmd_reg   <= CMD_NOP;
      cnt_reg   <= '0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      sen_reg   <= 1'b0;
      gate_reg  <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept && !cmd_is_nop) begin
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            if (cmd_ok) begin
              state_reg <= ST_HALT;
              cmd_reg   <= scan_cmd_e'(cmd_i);
              cnt_reg   <= shift_count_i;
              sen_reg   <= 1'b1;
              gate_reg  <= 1'b0;
            end else begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          state_reg <= ST_SHIFT;
          gate_reg  <= 1'b1;
        end
        ST_SHIFT: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CountWidth'(1)) begin
            state_reg <= ST_POST;
            sen_reg   <= 1'b0;
            gate_reg  <= 1'b0;
          end
        end
        ST_POST: begin
          state_reg <= ST_DONE;
          gate_reg  <= 1'b1;
          done_reg  <= 1'b1;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
          sen_reg   <= 1'b0;
          gate_reg  <= 1'b1;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NumChains; gi++) begin : g_lane
      logic [DataWidth-1:0] load_data;

      assign load_data = (cmd_i == 3'd1) ? '0 : shift_data_i[gi*DataWidth +: DataWidth];

      loom_scan_lane #(
        .DataWidth(DataWidth)
      ) u_lane (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (lane_load),
        .load_data_i (load_data),
        .shift_i     (lane_shift),
        .mode_i      (cmd_reg),
        .scan_out_i  (scan_out_i[gi]),
        .scan_in_o   (scan_in_o[gi]),
        .lane_o      (shift_data_o[gi*DataWidth +: DataWidth]),
        .parity_o    (parity_o[gi])
      );
    end
  endgenerate

endmodule
